// File: rtl/ccb_cfg_pkg.sv
// ccb_cfg_pkg: shared types and size helpers for the
// control connection block configuration loader.
package ccb_cfg_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      CHECK,
      DONE,
      ERR
   } state_t;

   // Select value applied at reset: east_in[0] on every input.
   localparam logic RST_SEL_BIT = 1'b0;

   function automatic int cfg_bits_f(
      input int sel_per_in,
      input int controlin
   );
      return sel_per_in * controlin;
   endfunction

   function automatic int nwords_f(
      input int cfg_bits,
      input int word
   );
      return (cfg_bits + word - 1) / word;
   endfunction

   function automatic int wcnt_w_f(input int nwords);
      return $clog2(nwords + 1);
   endfunction

endpackage

// File: rtl/ccb_sel_range_check.sv
// ccb_sel_range_check: flags any select field >= 2*W.
// Ports: sel (packed select image), oor (out-of-range flag).
module ccb_sel_range_check
   import ccb_cfg_pkg::*;
#(
   parameter int W          = 8,
   parameter int CONTROLIN  = 6,
   parameter int SEL_PER_IN = $clog2(W*2)
) (
   input  logic [SEL_PER_IN*CONTROLIN-1:0] sel,
   output logic                            oor
);

   // One extra bit so 2*W == 2**SEL_PER_IN is representable.
   localparam logic [SEL_PER_IN:0] LIM = (SEL_PER_IN+1)'(2*W);

   always_comb begin
      oor = 1'b0;
      for (int i = 0; i < CONTROLIN; i++) begin
         if ({1'b0, sel[i*SEL_PER_IN +: SEL_PER_IN]} >= LIM)
            oor = 1'b1;
      end
   end

endmodule

// File: rtl/ccb_config_loader.sv
// ccb_config_loader: streams a select image into a shadow register,
// range-checks it and commits it atomically to the c select bus.
// Ports: clk, rst_n (sync, active-low); start; cfg_valid/cfg_ready/
// cfg_data/cfg_last word stream; c committed selects; busy, done, err.
module ccb_config_loader
   import ccb_cfg_pkg::*;
#(
   parameter int W          = 8,
   parameter int CONTROLIN  = 6,
   parameter int SEL_PER_IN = $clog2(W*2),
   parameter int WORD       = 8
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            start,
   input  logic                            cfg_valid,
   output logic                            cfg_ready,
   input  logic [WORD-1:0]                 cfg_data,
   input  logic                            cfg_last,
   output logic [SEL_PER_IN*CONTROLIN-1:0] c,
   output logic                            busy,
   output logic                            done,
   output logic                            err
);

   localparam int CFG_BITS = cfg_bits_f(SEL_PER_IN, CONTROLIN);
   localparam int NWORDS   = nwords_f(CFG_BITS, WORD);
   localparam int WCNT_W   = wcnt_w_f(NWORDS);
   localparam int SH_BITS  = NWORDS * WORD;

   state_t              state;
   state_t              state_d;
   logic [SH_BITS-1:0]  shadow;
   logic [WCNT_W-1:0]   wcnt;
   logic                oor;
   logic                acc;
   logic                clr;
   logic                last_idx;
   logic                ready_d;
   logic                busy_d;
   logic                done_d;
   logic                err_d;

   ccb_sel_range_check #(
      .W          (W),
      .CONTROLIN  (CONTROLIN),
      .SEL_PER_IN (SEL_PER_IN)
   ) u_chk (
      .sel (shadow[CFG_BITS-1:0]),
      .oor (oor)
   );

   always_comb begin
      state_d  = state;
      clr      = 1'b0;
      acc      = cfg_valid && cfg_ready;
      last_idx = (wcnt == WCNT_W'(NWORDS-1));
      unique case (state)
         IDLE, DONE, ERR: begin
            if (start) begin
               state_d = LOAD;
               clr     = 1'b1;
            end
         end
         LOAD: begin
            // Image length must match exactly: last flag on last word only.
            if (acc) begin
               if (cfg_last != last_idx)
                  state_d = ERR;
               else if (last_idx)
                  state_d = CHECK;
            end
         end
         CHECK: begin
            state_d = oor ? ERR : DONE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // Outputs are registered copies of the next-state decode.
      ready_d = (state_d == LOAD);
      busy_d  = (state_d == LOAD) || (state_d == CHECK);
      err_d   = (state_d == ERR);
      done_d  = (state == CHECK) && !oor;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         c         <= {CFG_BITS{RST_SEL_BIT}};
         shadow    <= '0;
         wcnt      <= '0;
         cfg_ready <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         state     <= state_d;
         cfg_ready <= ready_d;
         busy      <= busy_d;
         done      <= done_d;
         err       <= err_d;
         if (clr) begin
            shadow <= '0;
            wcnt   <= '0;
         end else if (acc) begin
            for (int k = 0; k < NWORDS; k++) begin
               if (wcnt == WCNT_W'(k))
                  shadow[k*WORD +: WORD] <= cfg_data;
            end
            wcnt <= wcnt + WCNT_W'(1);
         end
         if (done_d)
            c <= shadow[CFG_BITS-1:0];
      end
   end

endmodule

// File: tb/tb_ccb_config_loader.sv
// tb_ccb_config_loader: directed checks of load, commit, error
// paths and reset abort; a W=6 instance covers range checking.
module tb_ccb_config_loader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, start6;
   logic        valid, valid6;
   logic [7:0]  data, data6;
   logic        last, last6;
   logic        ready, ready6;
   logic [23:0] c, c6;
   logic        busy, busy6;
   logic        done, done6;
   logic        err, err6;

   int tests_run = 0;
   int fails = 0;

   always #5 clk = ~clk;

   ccb_config_loader dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .cfg_valid (valid),
      .cfg_ready (ready),
      .cfg_data  (data),
      .cfg_last  (last),
      .c         (c),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   ccb_config_loader #(.W(6)) dut6 (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start6),
      .cfg_valid (valid6),
      .cfg_ready (ready6),
      .cfg_data  (data6),
      .cfg_last  (last6),
      .c         (c6),
      .busy      (busy6),
      .done      (done6),
      .err       (err6)
   );

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic kick(input bit d6);
      if (d6) start6 = 1'b1;
      else start = 1'b1;
      tick();
      start  = 1'b0;
      start6 = 1'b0;
   endtask

   task automatic push(input bit d6, input logic [7:0] d, input bit l);
      if (d6) begin
         valid6 = 1'b1; data6 = d; last6 = l;
      end else begin
         valid = 1'b1; data = d; last = l;
      end
      tick();
      valid = 1'b0; last = 1'b0;
      valid6 = 1'b0; last6 = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      tests_run++;
      if (c !== 24'h0) begin fails++; $display("FAIL reset_c got %h exp 000000", c); end
      tests_run++;
      if ({ready, busy, done, err} !== 4'b0) begin
         fails++; $display("FAIL reset_flags got %b exp 0000", {ready, busy, done, err});
      end
      tests_run++;
      if (c6 !== 24'h0) begin fails++; $display("FAIL reset_c6 got %h exp 000000", c6); end
   endtask

   task automatic test_nominal();
      kick(0);
      tests_run++;
      if ({ready, busy} !== 2'b11) begin
         fails++; $display("FAIL nom_ready got %b exp 11", {ready, busy});
      end
      push(0, 8'h21, 0);
      push(0, 8'h43, 0);
      tests_run++;
      if (c !== 24'h0) begin fails++; $display("FAIL nom_c_load got %h exp 000000", c); end
      push(0, 8'h65, 1);
      tests_run++;
      if ({ready, busy, done, c} !== {3'b010, 24'h0}) begin
         fails++; $display("FAIL nom_check got r%b b%b d%b c%h exp r0 b1 d0 c000000", ready, busy, done, c);
      end
      tick();
      tests_run++;
      if (done !== 1'b1 || c !== 24'h654321) begin
         fails++; $display("FAIL nom_commit got d%b c%h exp d1 c654321", done, c);
      end
      tests_run++;
      if (err !== 1'b0 || busy !== 1'b0) begin
         fails++; $display("FAIL nom_flags got e%b b%b exp e0 b0", err, busy);
      end
      tick();
      tests_run++;
      if (done !== 1'b0) begin fails++; $display("FAIL nom_pulse got %b exp 0", done); end
   endtask

   task automatic test_gaps();
      kick(0);
      push(0, 8'h98, 0);
      tick(); tick();
      tests_run++;
      if (c !== 24'h654321) begin fails++; $display("FAIL gap_hold1 got %h exp 654321", c); end
      push(0, 8'hBA, 0);
      tick(); tick();
      tests_run++;
      if (c !== 24'h654321 || ready !== 1'b1) begin
         fails++; $display("FAIL gap_hold2 got c%h r%b exp c654321 r1", c, ready);
      end
      push(0, 8'hDC, 1);
      tick();
      tests_run++;
      if (done !== 1'b1 || c !== 24'hDCBA98) begin
         fails++; $display("FAIL gap_commit got d%b c%h exp d1 cdcba98", done, c);
      end
   endtask

   task automatic test_short();
      kick(0);
      push(0, 8'h11, 0);
      push(0, 8'h22, 1);
      tests_run++;
      if ({err, ready, busy} !== 3'b100) begin
         fails++; $display("FAIL short_err got %b exp 100", {err, ready, busy});
      end
      tick();
      tests_run++;
      if (done !== 1'b0 || err !== 1'b1 || c !== 24'hDCBA98) begin
         fails++; $display("FAIL short_hold got d%b e%b c%h exp d0 e1 cdcba98", done, err, c);
      end
      push(0, 8'h33, 1);
      tick();
      tests_run++;
      if (ready !== 1'b0 || err !== 1'b1 || c !== 24'hDCBA98) begin
         fails++; $display("FAIL short_ignore got r%b e%b c%h exp r0 e1 cdcba98", ready, err, c);
      end
   endtask

   task automatic test_reset_mid();
      kick(0);
      push(0, 8'h77, 0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tests_run++;
      if ({c, busy, ready, err} !== {24'h0, 3'b000}) begin
         fails++; $display("FAIL mid_reset got c%h b%b r%b e%b exp c000000 b0 r0 e0", c, busy, ready, err);
      end
      tick();
      tests_run++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         fails++; $display("FAIL mid_idle got d%b b%b exp d0 b0", done, busy);
      end
      kick(0);
      push(0, 8'h21, 0);
      push(0, 8'h43, 0);
      push(0, 8'h65, 1);
      tick();
      tests_run++;
      if (done !== 1'b1 || c !== 24'h654321) begin
         fails++; $display("FAIL mid_reload got d%b c%h exp d1 c654321", done, c);
      end
   endtask

   task automatic test_long();
      kick(0);
      push(0, 8'h01, 0);
      push(0, 8'h02, 0);
      push(0, 8'h03, 0);
      tests_run++;
      if ({err, ready, busy} !== 3'b100) begin
         fails++; $display("FAIL long_err got %b exp 100", {err, ready, busy});
      end
      tick();
      tests_run++;
      if (done !== 1'b0 || c !== 24'h654321) begin
         fails++; $display("FAIL long_hold got d%b c%h exp d0 c654321", done, c);
      end
      kick(0);
      tests_run++;
      if ({err, ready, busy} !== 3'b011) begin
         fails++; $display("FAIL long_restart got %b exp 011", {err, ready, busy});
      end
   endtask

   task automatic test_oor();
      kick(1);
      push(1, 8'h10, 0);
      push(1, 8'h3C, 0);
      push(1, 8'h54, 1);
      tests_run++;
      if (busy6 !== 1'b1 || err6 !== 1'b0) begin
         fails++; $display("FAIL oor_check got b%b e%b exp b1 e0", busy6, err6);
      end
      tick();
      tests_run++;
      if ({err6, done6, c6} !== {2'b10, 24'h0}) begin
         fails++; $display("FAIL oor_reject got e%b d%b c%h exp e1 d0 c000000", err6, done6, c6);
      end
      kick(1);
      push(1, 8'h10, 0);
      push(1, 8'h3B, 0);
      push(1, 8'h54, 1);
      tick();
      tests_run++;
      if ({err6, done6, c6} !== {2'b01, 24'h543B10}) begin
         fails++; $display("FAIL oor_accept got e%b d%b c%h exp e0 d1 c543b10", err6, done6, c6);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0; start6 = 1'b0;
      valid = 1'b0; valid6 = 1'b0;
      data = 8'h0; data6 = 8'h0;
      last = 1'b0; last6 = 1'b0;
      tick();
      test_reset();
      test_nominal();
      test_gaps();
      test_short();
      test_reset_mid();
      test_long();
      test_oor();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
